pacman_sfx_player: RTL
======================

# pacman_sfx_player

Parametrised sound-effect sequencer for the Pacman audio path. It walks a per-effect table of tone half-periods held in an external synchronous lookup ROM, from a caller-supplied start address until an end-of-table code. Each entry plays as a square wave for a fixed step duration. The block sits between the game FSM (start/abort/done) and the speaker output, and lets one engine serve every effect table.

## Interface
- ADDR_W, 10, ROM address width
- DATA_W, 9, ROM entry width (half-period in TONE_DIV units)
- END_CODE, 2**DATA_W-1, end-of-table marker
- STEP_CYCLES, 1000, clk cycles each entry plays (≥1)
- TONE_DIV, 16, clk cycles per half-period unit (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start request, sampled in IDLE only
- start_addr  in  ADDR_W  first table entry of the effect, captured with start
- loop  in  1  restart from captured start address at END_CODE; captured with start
- abort  in  1  stop immediately, from any state
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  DATA_W  ROM output, valid the cycle after the edge that samples rom_addr
- busy  out  1  high from the cycle after accepted start until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- audio  out  1  square-wave output
- cur_period  out  DATA_W  entry currently playing

## Operation
- Reset: state IDLE; rom_addr=0, busy=0, done=0, audio=0, cur_period=0; all counters 0.
- States: IDLE, FETCH, LATCH, PLAY, DONE.
- IDLE: start=1 and abort=0 → rom_addr←start_addr; capture start_addr and loop; clear played flag; go FETCH.
- FETCH: one wait cycle while the ROM samples rom_addr; go LATCH.
- LATCH, rom_data≠END_CODE: cur_period←rom_data; step counter←STEP_CYCLES-1; tone counters and audio cleared; set played flag; go PLAY.
- LATCH, rom_data=END_CODE:
  - loop=1 and played flag set → rom_addr←captured start; clear played flag; go FETCH.
  - Otherwise → go DONE. An empty table never spins under loop.
- PLAY: step counter decrements each cycle. At 0 → rom_addr←rom_addr+1 (mod 2^ADDR_W, wraps all-ones→0); go FETCH.
- Tone, in PLAY only:
  - Divider counts TONE_DIV cycles; each expiry increments the half counter.
  - Half counter reaching cur_period → toggle audio, clear the half counter.
  - cur_period=0 → audio held 0 (rest).
  - audio=0 in every other state.
- DONE: done=1 for this one cycle; busy=0; cur_period←0; go IDLE.
- abort=1 in any non-IDLE state → IDLE next cycle; busy, audio and cur_period cleared; no done pulse. abort has priority over start and over all transitions.
- start outside IDLE is ignored, including in the DONE cycle. The request is not queued.
- rst_n low mid-operation → immediate return to reset values; no done.

## Timing
- start sampled at edge 0 → busy=1 and FETCH in cycle 1; LATCH in cycle 2; PLAY cycles 3..2+STEP_CYCLES.
- Each entry occupies STEP_CYCLES+2 cycles. The FETCH/LATCH gap between entries is silent.
- First audio toggle comes after cur_period·TONE_DIV PLAY cycles. Then audio toggles every cur_period·TONE_DIV cycles.
- END_CODE seen in LATCH cycle n → done=1 in cycle n+1; busy=0 from cycle n+1; start accepted from cycle n+2.
- All outputs are registered; there is no combinational input→output path.

## Test plan
Common setup: STEP_CYCLES=4, TONE_DIV=1, ROM model with 1-cycle latency, table {0:2, 1:0, 2:511}. start_addr=0 unless stated.
- Basic run, loop=0, start at edge 0 → all of:
  - busy=1 in cycles 1–14.
  - audio 0 in cycles 3–4, 1 in cycles 5–6.
  - audio 0 in cycles 7–14.
  - cur_period=2 in cycles 3–8, 0 in cycles 9–14.
  - rom_addr sequence 0,1,2.
  - done=1 only in cycle 15; busy=0 from cycle 15.
- Loop, same table, loop=1 → rom_addr returns to 0 in cycle 15; entry 0 replays in cycles 17–20; done never asserts.
- Empty table, start_addr=2, loop=1 → done pulses in cycle 3; busy=0 in cycle 3; audio stays 0.
- Abort in cycle 4 → busy=0 and audio=0 in cycle 5; no done. New start sampled at edge 5 gives busy=1 in cycle 6.
- Address wrap, ADDR_W=4, table {15:3, 0:511}, start_addr=15 → rom_addr 15 then 0; done pulses after entry 15.
- start pulsed in cycles 3 and 15 during the basic run → ignored; sequence identical to the basic run. rst_n low in cycle 5 → all outputs reset immediately.

Source files
------------

// File: rtl/pacman_sfx_player.sv
// pacman_sfx_player: sound-effect sequencer for the Pacman audio path.
// Walks a table of tone half-periods in an external synchronous ROM, starting
// at start_addr and stopping at END_CODE (or restarting when loop is set).
// Each entry plays as a square wave for STEP_CYCLES clocks.
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   start, start_addr  start request and first table address (IDLE only)
//   loop               restart at end of table, captured with start
//   abort              return to IDLE from any state, no done pulse
//   rom_addr/rom_data  registered ROM address / ROM data (1-cycle latency)
//   busy, done         activity flag / one-cycle completion pulse
//   audio, cur_period  square-wave output / half-period being played
module pacman_sfx_player #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 9,
  parameter int END_CODE    = 2**DATA_W-1,
  parameter int STEP_CYCLES = 1000,
  parameter int TONE_DIV    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              loop,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic              audio,
  output logic [DATA_W-1:0] cur_period
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int DIV_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [DATA_W-1:0] END_V     = DATA_W'(END_CODE);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TONE_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_PLAY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                loop_q, loop_d;
  logic                played_q, played_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                audio_q, audio_d;
  logic [DATA_W-1:0]   cur_q, cur_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DATA_W-1:0]   half_q, half_d;
  logic [DATA_W-1:0]   half_nxt;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    base_d     = base_q;
    loop_d     = loop_q;
    played_d   = played_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    audio_d    = 1'b0;   // audio only survives while staying in PLAY
    cur_d      = cur_q;
    step_d     = step_q;
    div_d      = div_q;
    half_d     = half_q;
    half_nxt   = half_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          rom_addr_d = start_addr;
          base_d     = start_addr;
          loop_d     = loop;
          played_d   = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (rom_data != END_V) begin
          cur_d    = rom_data;
          step_d   = STEP_LAST;
          div_d    = '0;
          half_d   = '0;
          played_d = 1'b1;
          state_d  = S_PLAY;
        end else if (loop_q && played_q) begin
          // Only loop if at least one entry played, so an empty table ends.
          rom_addr_d = base_q;
          played_d   = 1'b0;
          state_d    = S_FETCH;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cur_d   = '0;
          state_d = S_DONE;
        end
      end
      S_PLAY: begin
        audio_d = audio_q;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (half_nxt == cur_q) begin
            audio_d = ~audio_q;
            half_d  = '0;
          end else begin
            half_d = half_nxt;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
        if (cur_q == '0) audio_d = 1'b0;   // rest entry
        if (step_q == '0) begin
          rom_addr_d = rom_addr_q + 1'b1;  // wraps naturally at all-ones
          audio_d    = 1'b0;
          state_d    = S_FETCH;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // abort overrides every transition computed above
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      audio_d = 1'b0;
      cur_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      base_q     <= '0;
      loop_q     <= 1'b0;
      played_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      audio_q    <= 1'b0;
      cur_q      <= '0;
      step_q     <= '0;
      div_q      <= '0;
      half_q     <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      base_q     <= base_d;
      loop_q     <= loop_d;
      played_q   <= played_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      audio_q    <= audio_d;
      cur_q      <= cur_d;
      step_q     <= step_d;
      div_q      <= div_d;
      half_q     <= half_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign audio      = audio_q;
  assign cur_period = cur_q;

endmodule
